// File: rtl/npu_out_packer_pkg.sv
// Shared definitions for the NPU output packer: state encoding, word geometry
// and the byte-enable mask for partial words.
package npu_out_packer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Thermometer mask for a word holding 'lanes' valid bytes (1..4).
  function automatic logic [BE_W-1:0] be_mask(input logic [2:0] lanes);
    logic [BE_W-1:0] m;
    case (lanes)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/npu_out_packer_word_fifo.sv
// First-word-fall-through word FIFO with a registered head (data + valid) and
// an occupancy count that covers the head entry.
module npu_word_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 36,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_X,
  input  logic             SOFT_RESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             head_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             pop, push_acc;

  always_comb begin
    pop      = pop_i & head_valid_q;
    push_acc = push_i & ((count_q < FULL_LVL) | pop);
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    if (push_acc) wr_d = wr_q + 1'b1;
    if (pop)      rd_d = rd_q + 1'b1;
    if (push_acc && !pop)      count_d = count_q + 1'b1;
    else if (!push_acc && pop) count_d = count_q - 1'b1;
    // The head register mirrors the next head entry; a push into an empty
    // (or just-emptied) FIFO bypasses memory so it is visible one edge later.
    head_valid_d = (count_d != '0);
    if (count_d == '0)                  head_d = '0;
    else if (push_acc && (wr_q == rd_d)) head_d = push_data_i;
    else                                 head_d = mem_q[rd_d];
  end

  always_ff @(posedge CLK) begin
    if (push_acc) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else if (SOFT_RESET) begin
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;
  assign full_o       = (count_q == FULL_LVL);
  assign empty_o      = (count_q == '0);
  assign level_o      = count_q;

endmodule

// File: rtl/npu_out_packer.sv
// Packs the npu_core byte stream little-endian into 32-bit words, tags the
// final partial word with byte enables and buffers words for the bus side.
module npu_out_packer
  import npu_out_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_X,
  input  logic                          SOFT_RESET,
  input  logic                          START,
  input  logic [CNT_W-1:0]              LEN,
  input  logic                          IN_EN,
  input  logic [7:0]                    IN_DATA,
  output logic                          OUT_VALID,
  output logic [WORD_W-1:0]             OUT_DATA,
  output logic [BE_W-1:0]               OUT_BE,
  input  logic                          OUT_READY,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int unsigned ENTRY_W = WORD_W + BE_W;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [1:0]           idx_q, idx_d;
  logic [WORD_W-1:0]    word_q, word_d, word_nxt;
  logic                 push_q, push_d;
  logic [ENTRY_W-1:0]   push_word_q, push_word_d, head;
  logic                 busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic                 fifo_full, fifo_empty, fifo_pop, drop;

  assign fifo_pop = OUT_VALID & OUT_READY;
  assign drop     = push_q & fifo_full & ~fifo_pop;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    overflow_d  = overflow_q | drop;
    cnt_inc     = cnt_q + 1'b1;
    word_nxt    = (idx_q == 2'd0) ? '0 : word_q;
    word_nxt[{idx_q, 3'b000} +: 8] = IN_DATA;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          len_d      = LEN;
          cnt_d      = '0;
          idx_d      = '0;
          overflow_d = 1'b0;
          state_d    = (LEN == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (IN_EN) begin
          cnt_d  = cnt_inc;
          word_d = word_nxt;
          if (idx_q == 2'd3 || cnt_inc == len_q) begin
            push_d      = 1'b1;
            push_word_d = {be_mask({1'b0, idx_q} + 3'd1), word_nxt};
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (cnt_inc == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !push_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (SOFT_RESET) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  npu_word_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .CLK          (CLK),
    .RESET_X      (RESET_X),
    .SOFT_RESET   (SOFT_RESET),
    .push_i       (push_q),
    .push_data_i  (push_word_q),
    .pop_i        (OUT_READY),
    .head_o       (head),
    .head_valid_o (OUT_VALID),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .level_o      (LEVEL)
  );

  assign OUT_DATA = head[WORD_W-1:0];
  assign OUT_BE   = head[ENTRY_W-1:WORD_W];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: doc/npu_out_packer.md
Name: npu_out_packer

Overview:
- Downstream of npu_core; consumes its OUTPUT_EN/C_OUT byte stream.
- Packs bytes little-endian into 32-bit words and buffers them in a small FIFO.
- Presents the words to the DMA/bus side with a valid/ready handshake.
- A per-job byte count marks the final, possibly partial, word.

Parameters:
- FIFO_DEPTH, 16, number of 32-bit word entries; power of two, minimum 2.
- CNT_W, 16, width of the job byte counter and of LEN.

Ports:
- CLK  in  1  system clock.
- RESET_X  in  1  asynchronous active-low reset.
- SOFT_RESET  in  1  synchronous active-high clear; same effect as reset, applied on the clock edge.
- START  in  1  one-cycle pulse; latches LEN and begins a job.
- LEN  in  CNT_W  number of bytes expected in the job.
- IN_EN  in  1  byte valid (driven by npu_core OUTPUT_EN).
- IN_DATA  in  8  byte (driven by npu_core C_OUT).
- OUT_VALID  out  1  FIFO head valid.
- OUT_DATA  out  32  FIFO head word.
- OUT_BE  out  4  byte enables of the head word.
- OUT_READY  in  1  consumer accepts the head word this cycle.
- BUSY  out  1  job in progress.
- DONE  out  1  job complete and FIFO drained; held until next START.
- OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset or SOFT_RESET:
  - All outputs 0: OUT_VALID, OUT_DATA, OUT_BE, BUSY, DONE, OVERFLOW, LEVEL.
  - FIFO emptied, state IDLE, byte counter and lane index 0.
  - Reset mid-job discards the partial word and all buffered words.
- States:
  - IDLE: START goes to RUN if LEN≠0; goes to DONE if LEN=0 (no words produced). IN_EN ignored.
  - RUN: BUSY=1. Each IN_EN cycle places IN_DATA in lane idx (bits 8*idx+7:8*idx), then increments idx and the byte count. A word is pushed when idx reaches 3 or the byte is the LEN-th byte. Then idx returns to 0. Go to DRAIN after the LEN-th byte is accepted.
  - RUN extra bytes: IN_EN beyond LEN is not possible in RUN (the state changes on the LEN-th byte); IN_EN in DRAIN/DONE/IDLE is ignored.
  - DRAIN: BUSY=1. Go to DONE when the FIFO is empty and no push is pending.
  - DONE: BUSY=0, DONE=1.
  - START in DONE or IDLE starts a new job: clears DONE and OVERFLOW and latches LEN. START in RUN/DRAIN is ignored.
- OUT_BE of a pushed word:
  - Full word: 4'b1111.
  - Final partial word: thermometer mask by lane count (1→0001, 2→0011, 3→0111).
  - Unused lanes are 0.
- Latency: the byte completing a word is sampled at edge t; OUT_VALID=1 with that word from edge t+1 (FIFO empty case). Throughput is one byte per cycle sustained; no backpressure to npu_core exists.
- FIFO behaviour:
  - First-word-fall-through; OUT_DATA/OUT_BE/OUT_VALID are registered.
  - Pop occurs when OUT_VALID & OUT_READY.
  - OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- Simultaneous push and pop: a push is accepted if LEVEL<FIFO_DEPTH or a pop occurs in the same cycle. LEVEL is unchanged on simultaneous push+pop.
- Full FIFO: a push with LEVEL=FIFO_DEPTH and no pop drops the word and sets OVERFLOW. The byte count still advances, so the job still terminates.
- Pointers wrap modulo FIFO_DEPTH. LEVEL ranges 0..FIFO_DEPTH.
- The byte counter compares against the latched LEN; a LEN change during a job has no effect.

Decomposition:
- Shared npu package holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3);
  - the byte-enable mask function;
  - the word width constant 32.
- One sub-module, npu_word_fifo: synchronous FWFT FIFO, 36 bits wide (32 data + 4 BE), parameterised by depth, with push/pop/full/empty/level outputs. It uses the same CLK, RESET_X and SOFT_RESET.

Test Plan:
- LEN=8; bytes 0x01..0x08 back-to-back; OUT_READY=1 → words 0x04030201 then 0x08070605, BE=1111. First word valid one cycle after byte 4. DONE=1 after the second pop.
- LEN=6; bytes 0xA0..0xA5 → 0xA3A2A1A0/1111, then 0x0000A5A4/0011. Then DONE=1, BUSY=0.
- FIFO_DEPTH=16; OUT_READY=0; LEN=72 (18 words) → LEVEL=16 and OVERFLOW=1 after word 17. Then OUT_READY=1 → 16 words drain (words 1..16), then DONE=1.
- LEVEL=16 with a push and a pop on the same edge → push accepted, LEVEL stays 16, OVERFLOW stays 0.
- START with LEN=0 → DONE=1 next cycle, OUT_VALID never asserted. Further IN_EN bytes are ignored.
- Mid-job (5 bytes in, 1 word buffered) RESET_X low → all outputs 0 immediately. After release, a new job with LEN=4 and bytes 0x11..0x14 → single word 0x14131211.
